redun_mont_seq: RTL and testbench

REDUN_MONT_SEQ -- requirements
Module: redun_mont_seq

---
 rtl/redun_mont_seq.sv | 148 ++++++++++++++
 tb/tb_redun_mont_seq.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/redun_mont_seq.sv
// Sequencer for repeated Montgomery squaring in redundant form: issues one operand at a time and feeds each product back.
// Optional watchdog on the product wait enabled by defining REDUN_MONT_SEQ_TIMEOUT_EN.
module redun_mont_seq #(
  parameter int DAT_BITS    = 1088,
  parameter int ITER_BITS   = 64,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [DAT_BITS-1:0]  i_sq_init,
  input  logic [ITER_BITS-1:0] i_iter,
  input  logic                 i_abort,
  output logic [DAT_BITS-1:0]  o_mul_sq,
  output logic                 o_mul_val,
  input  logic [DAT_BITS-1:0]  i_mul_res,
  input  logic                 i_mul_val,
  input  logic                 i_mul_overflow,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err,
  output logic [DAT_BITS-1:0]  o_res,
  output logic [ITER_BITS-1:0] o_iter_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [DAT_BITS-1:0]  opnd_q, opnd_d;
  logic [DAT_BITS-1:0]  res_q, res_d;
  logic [ITER_BITS-1:0] cnt_q, cnt_d;
  logic [ITER_BITS-1:0] tgt_q, tgt_d;
  logic                 err_q, err_d;
  logic                 done_q, done_d;
  logic [ITER_BITS-1:0] cnt_inc;

`ifdef REDUN_MONT_SEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

  // Count saturates so a pathological target can never wrap it.
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    opnd_d  = opnd_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    err_d   = err_q;
    done_d  = 1'b0;
`ifdef REDUN_MONT_SEQ_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif
    case (state_q)
      S_IDLE, S_ERR: begin
        if (i_start) begin
          tgt_d   = i_iter;
          opnd_d  = i_sq_init;
          res_d   = i_sq_init;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = (i_iter == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
`ifdef REDUN_MONT_SEQ_TIMEOUT_EN
        tmo_d = '0;
`endif
        state_d = i_abort ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        // Abort takes priority; a product arriving with it is dropped.
        if (i_abort) begin
          state_d = S_IDLE;
        end else if (i_mul_val) begin
          res_d = i_mul_res;
          cnt_d = cnt_inc;
          if (i_mul_overflow) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else if (cnt_inc == tgt_q) begin
            state_d = S_DONE;
          end else begin
            opnd_d  = i_mul_res;
            state_d = S_ISSUE;
          end
        end
`ifdef REDUN_MONT_SEQ_TIMEOUT_EN
        else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      opnd_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      tgt_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opnd_q  <= opnd_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

`ifdef REDUN_MONT_SEQ_TIMEOUT_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`endif

  assign o_mul_val  = (state_q == S_ISSUE);
  assign o_mul_sq   = o_mul_val ? opnd_q : '0;
  assign o_busy     = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign o_done     = done_q;
  assign o_err      = err_q;
  assign o_res      = res_q;
  assign o_iter_cnt = cnt_q;

endmodule

// File: tb/tb_redun_mont_seq.sv
// Directed and randomized bench for redun_mont_seq with a behavioural latency stub for the squaring datapath.
// Honours REDUN_MONT_SEQ_TIMEOUT_EN for the watchdog step.
module tb_redun_mont_seq;
  localparam int DW = 128;
  localparam int IW = 16;
  localparam int TO = 16;
  localparam logic [31:0] MOD_N = 32'd65521;

  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, abort = 1'b0, mul_val = 1'b0, mul_ovf = 1'b0;
  logic [DW-1:0] sq_init = '0, mul_res = '0;
  logic [IW-1:0] iter = '0;
  logic [DW-1:0] o_mul_sq, o_res;
  logic o_mul_val, o_busy, o_done, o_err;
  logic [IW-1:0] o_iter_cnt;

  redun_mont_seq #(.DAT_BITS(DW), .ITER_BITS(IW), .TIMEOUT_CYC(TO)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_sq_init(sq_init), .i_iter(iter),
    .i_abort(abort), .o_mul_sq(o_mul_sq), .o_mul_val(o_mul_val), .i_mul_res(mul_res),
    .i_mul_val(mul_val), .i_mul_overflow(mul_ovf), .o_busy(o_busy), .o_done(o_done),
    .o_err(o_err), .o_res(o_res), .o_iter_cnt(o_iter_cnt)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stub configuration (written by the stimulus only)
  int stub_lat = 5, stub_mode = 0, ovf_at = 0, abort_at = 0;
  bit silent = 1'b0;
  int run_id = 0, stray_id = 0;
  // Stub state (written by the stub only)
  int seen_run = 0, seen_stray = 0;
  bit pend = 1'b0;
  int pcnt = 0, prod_idx = 0, pulses = 0, done_cnt = 0;
  int lat_errs = 0, sq_errs = 0;
  int last_resp_cyc = 0, last_pulse_cyc = 0, last_done_cyc = 0;
  logic [DW-1:0] popnd = '0;
  int st_cyc = 0;

  function automatic logic [31:0] mont(input logic [31:0] a, input logic [31:0] b);
    logic [33:0] t = '0;
    for (int i = 0; i < 16; i++) begin
      if (a[i]) t = t + 34'(b);
      if (t[0]) t = t + 34'(MOD_N);
      t = t >> 1;
    end
    if (t >= 34'(MOD_N)) t = t - 34'(MOD_N);
    return t[31:0];
  endfunction

  function automatic logic [DW-1:0] dp(input int mode, input logic [DW-1:0] a);
    case (mode)
      0:       return a + 1;
      1:       return a * 3 + 1;
      default: return DW'(mont(a[31:0], a[31:0]));
    endcase
  endfunction

  function automatic logic [DW-1:0] model(input logic [DW-1:0] init, input int n, input int mode);
    logic [DW-1:0] v = init;
    for (int k = 0; k < n; k++) v = dp(mode, v);
    return v;
  endfunction

  // Datapath stub, driven away from the active edge.
  always @(negedge clk) begin
    mul_val = 1'b0;
    mul_ovf = 1'b0;
    abort   = 1'b0;
    if (run_id != seen_run) begin
      seen_run = run_id; pend = 1'b0; prod_idx = 0; pulses = 0; done_cnt = 0;
    end
    if (stray_id != seen_stray) begin
      seen_stray = stray_id; mul_val = 1'b1; mul_res = DW'(32'hBADBAD);
    end
    if (pend) begin
      pcnt--;
      if (pcnt == 0) begin
        pend = 1'b0;
        prod_idx++;
        mul_val = 1'b1;
        mul_res = dp(stub_mode, popnd);
        mul_ovf = (prod_idx == ovf_at);
        abort   = (prod_idx == abort_at);
        last_resp_cyc = cyc;
      end
    end
    if (o_mul_val) begin
      pulses++;
      last_pulse_cyc = cyc;
      if (prod_idx > 0 && cyc != last_resp_cyc + 1) lat_errs++;
      if (!silent) begin pend = 1'b1; pcnt = stub_lat; popnd = o_mul_sq; end
    end else if (o_mul_sq != '0) begin
      sq_errs++;
    end
    if (o_done) begin done_cnt++; last_done_cyc = cyc; end
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_run(input logic [DW-1:0] init, input int n, input int mode, input int lat,
                           input int ovf, input int ab, input bit sil);
    @(posedge clk);
    stub_mode = mode; stub_lat = lat; ovf_at = ovf; abort_at = ab; silent = sil; run_id++;
    @(negedge clk);
    start = 1'b1; sq_init = init; iter = IW'(n); st_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (o_done || o_err) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (!o_busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "bench watchdog");
  end

  initial begin
    bit ok;
    logic [DW-1:0] init, expv;
    int n, lat, delta;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    settle(1);
    chk("rst_busy", DW'(o_busy), DW'(0));
    chk("rst_done", DW'(o_done), DW'(0));
    chk("rst_err",  DW'(o_err),  DW'(0));
    chk("rst_res",  o_res,       DW'(0));
    chk("rst_cnt",  DW'(o_iter_cnt), DW'(0));
    chk("rst_mval", DW'(o_mul_val), DW'(0));

    // Zero iterations: completes straight away with the start value.
    start_run(DW'(5), 0, 0, 5, 0, 0, 1'b0);
    wait_end(20, ok);
    chk("z_ended", DW'(ok), DW'(1));
    settle(3);
    chk("z_lat",    DW'(last_done_cyc - st_cyc), DW'(2));
    chk("z_res",    o_res, DW'(5));
    chk("z_pulses", DW'(pulses), DW'(0));
    chk("z_cnt",    DW'(o_iter_cnt), DW'(0));
    $display("txn zero_iter res=%0h done=%0d", o_res, done_cnt);

    // Ten iterations through an increment stub with latency 5.
    start_run(DW'(32'h100), 10, 0, 5, 0, 0, 1'b0);
    wait_end(400, ok);
    chk("inc_ended", DW'(ok), DW'(1));
    settle(3);
    chk("inc_pulses", DW'(pulses), DW'(10));
    chk("inc_res",    o_res, DW'(32'h10A));
    chk("inc_cnt",    DW'(o_iter_cnt), DW'(10));
    chk("inc_done",   DW'(done_cnt), DW'(1));
    $display("txn inc10 res=%0h cnt=%0d", o_res, o_iter_cnt);

    // Montgomery squaring of 2 three times gives 2^8 mod N in normal form.
    start_run(DW'((32'd2 << 16) % MOD_N), 3, 2, 3, 0, 0, 1'b0);
    wait_end(200, ok);
    chk("mont_ended", DW'(ok), DW'(1));
    settle(3);
    chk("mont_norm", DW'(mont(o_res[31:0], 32'd1)), DW'(32'd256 % MOD_N));
    chk("mont_done", DW'(done_cnt), DW'(1));
    $display("txn mont res=%0h", o_res);

    // Overflow on the third product.
    start_run(DW'(32'h40), 8, 0, 2, 3, 0, 1'b0);
    wait_end(200, ok);
    chk("ovf_ended", DW'(ok), DW'(1));
    settle(10);
    chk("ovf_err",    DW'(o_err), DW'(1));
    chk("ovf_cnt",    DW'(o_iter_cnt), DW'(3));
    chk("ovf_done",   DW'(done_cnt), DW'(0));
    chk("ovf_pulses", DW'(pulses), DW'(3));
    chk("ovf_busy",   DW'(o_busy), DW'(0));
    start_run(DW'(7), 1, 0, 2, 0, 0, 1'b0);
    settle(0);
    chk("ovf_clear", DW'(o_err), DW'(0));
    wait_end(200, ok);
    settle(2);
    chk("ovf_rerun", o_res, DW'(8));
    $display("txn overflow err_cleared res=%0h", o_res);

    // Abort coinciding with the fourth product, then a stray product.
    start_run(DW'(32'h200), 10, 0, 2, 0, 4, 1'b0);
    wait_idle(200, ok);
    chk("ab_idle", DW'(ok), DW'(1));
    settle(3);
    chk("ab_cnt",  DW'(o_iter_cnt), DW'(3));
    chk("ab_res",  o_res, DW'(32'h203));
    chk("ab_done", DW'(done_cnt), DW'(0));
    @(posedge clk); stray_id++;
    settle(4);
    chk("stray_cnt",  DW'(o_iter_cnt), DW'(3));
    chk("stray_res",  o_res, DW'(32'h203));
    chk("stray_busy", DW'(o_busy), DW'(0));
    start_run(DW'(32'h300), 2, 0, 3, 0, 0, 1'b0);
    wait_end(200, ok);
    settle(3);
    chk("ab_rerun_res",  o_res, DW'(32'h302));
    chk("ab_rerun_cnt",  DW'(o_iter_cnt), DW'(2));
    chk("ab_rerun_done", DW'(done_cnt), DW'(1));
    $display("txn abort res=%0h cnt=%0d", o_res, o_iter_cnt);

    // A start while busy is ignored.
    start_run(DW'(32'h1000), 5, 0, 4, 0, 0, 1'b0);
    settle(3);
    @(negedge clk); start = 1'b1; sq_init = DW'(32'hDEAD); iter = IW'(1);
    @(negedge clk); start = 1'b0;
    wait_end(300, ok);
    settle(3);
    chk("busy_start_res", o_res, DW'(32'h1005));
    chk("busy_start_cnt", DW'(o_iter_cnt), DW'(5));
    $display("txn ignored_start res=%0h", o_res);

    // Randomized runs against the arithmetic model.
    for (int r = 0; r < 6; r++) begin
      init = {$urandom, $urandom, $urandom, $urandom};
      n    = int'($urandom_range(8, 1));
      lat  = int'($urandom_range(6, 1));
      expv = model(init, n, 1);
      start_run(init, n, 1, lat, 0, 0, 1'b0);
      wait_end(500, ok);
      settle(3);
      chk("rnd_res",    o_res, expv);
      chk("rnd_cnt",    DW'(o_iter_cnt), DW'(n));
      chk("rnd_pulses", DW'(pulses), DW'(n));
      $display("txn random n=%0d lat=%0d res=%0h exp=%0h", n, lat, o_res, expv);
    end

    // Reset mid-run overrides a simultaneous start.
    start_run(DW'(32'h55), 10, 0, 5, 0, 0, 1'b0);
    settle(8);
    @(negedge clk); rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    chk("mrst_busy", DW'(o_busy), DW'(0));
    chk("mrst_mval", DW'(o_mul_val), DW'(0));
    chk("mrst_msq",  o_mul_sq, DW'(0));
    chk("mrst_res",  o_res, DW'(0));
    chk("mrst_cnt",  DW'(o_iter_cnt), DW'(0));
    @(negedge clk); rst = 1'b0; start = 1'b0;
    $display("txn midrun_reset busy=%0d", o_busy);

    // Datapath that never answers.
    start_run(DW'(32'h77), 3, 0, 5, 0, 0, 1'b1);
`ifdef REDUN_MONT_SEQ_TIMEOUT_EN
    wait_end(60, ok);
    chk("to_err_seen", DW'(ok), DW'(1));
    delta = cyc - last_pulse_cyc;
    chk("to_delta", DW'(delta == 16 || delta == 17), DW'(1));
    chk("to_err",  DW'(o_err), DW'(1));
    chk("to_busy", DW'(o_busy), DW'(0));
`else
    delta = 0;
    settle(1000);
    chk("hang_busy", DW'(o_busy), DW'(1));
`endif
    $display("txn no_response busy=%0d err=%0d delta=%0d", o_busy, o_err, delta);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;

    chk("fb_latency", DW'(lat_errs), DW'(0));
    chk("sq_zero",    DW'(sq_errs), DW'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
